// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of one system bus shared by an instruction cache (m0) and a data cache (m1)
// Ports: clk, reset (async, active-low);
//   per requester mN_*: reqcyc/req/reqtag in, reqack out, respcyc/resp/resptag out, respack in;
//   bus_*: reqcyc/req/reqtag out, reqack in, respcyc/resp/resptag in, respack out.
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
  output logic                      m0_reqack,
  output logic                      m0_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
  input  logic                      m0_respack,
  input  logic                      m1_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
  output logic                      m1_reqack,
  output logic                      m1_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
  input  logic                      m1_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);
  localparam int RD_BIT = 12;
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;
  state_t state;
  logic owner, rd, last;
  logic [2:0] cnt;
  logic grant, xfer, resp;
  logic own_reqcyc, own_respack;
  // only m1 requesting, or both requesting with m0 granted last
  assign grant = m1_reqcyc & (~m0_reqcyc | ~last);
  assign own_reqcyc = owner ? m1_reqcyc : m0_reqcyc;
  assign own_respack = owner ? m1_respack : m0_respack;
  assign xfer = (state == ADDR) || (state == WDATA);
  assign resp = state == RESP;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      owner <= 1'b0;
      rd    <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (m0_reqcyc || m1_reqcyc) begin
            owner <= grant;
            last  <= grant;
            rd    <= grant ? m1_reqtag[RD_BIT] : m0_reqtag[RD_BIT];
            state <= ADDR;
          end
        ADDR:
          if (own_reqcyc && bus_reqack) begin
            cnt   <= '0;
            state <= rd ? RESP : WDATA;
          end
        WDATA:
          if (own_reqcyc && bus_reqack) begin
            cnt <= cnt + 3'd1;
            if (cnt == LAST_BEAT) state <= IDLE;
          end
        default:
          if (bus_respcyc && own_respack) begin
            cnt <= cnt + 3'd1;
            if (cnt == LAST_BEAT) state <= IDLE;
          end
      endcase
    end
  always_comb begin
    bus_reqcyc  = xfer & own_reqcyc;
    bus_req     = xfer ? (owner ? m1_req : m0_req) : '0;
    bus_reqtag  = xfer ? (owner ? m1_reqtag : m0_reqtag) : '0;
    m0_reqack   = xfer & ~owner & bus_reqack;
    m1_reqack   = xfer & owner & bus_reqack;
    bus_respack = resp & own_respack;
    m0_respcyc  = resp & ~owner & bus_respcyc;
    m1_respcyc  = resp & owner & bus_respcyc;
    m0_resp     = (resp & ~owner) ? bus_resp : '0;
    m1_resp     = (resp & owner) ? bus_resp : '0;
    m0_resptag  = (resp & ~owner) ? bus_resptag : '0;
    m1_resptag  = (resp & owner) ? bus_resptag : '0;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized two-master / one-slave traffic against a transfer-order scoreboard
module tb_bus_arbiter;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int NB = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] mreqcyc, mrespack, mreqack, mrespcyc;
  logic [DW-1:0] mreq [2];
  logic [DW-1:0] mresp [2];
  logic [TW-1:0] mreqtag [2];
  logic [TW-1:0] mresptag [2];
  logic bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [DW-1:0] bus_req, bus_resp;
  logic [TW-1:0] bus_reqtag, bus_resptag;
  logic [236:0] outs;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(NB)) dut (
    .clk(clk), .reset(reset),
    .m0_reqcyc(mreqcyc[0]), .m0_req(mreq[0]), .m0_reqtag(mreqtag[0]), .m0_reqack(mreqack[0]),
    .m0_respcyc(mrespcyc[0]), .m0_resp(mresp[0]), .m0_resptag(mresptag[0]), .m0_respack(mrespack[0]),
    .m1_reqcyc(mreqcyc[1]), .m1_req(mreq[1]), .m1_reqtag(mreqtag[1]), .m1_reqack(mreqack[1]),
    .m1_respcyc(mrespcyc[1]), .m1_resp(mresp[1]), .m1_resptag(mresptag[1]), .m1_respack(mrespack[1]),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );
  assign outs = {mreqack, mrespcyc, mresp[0], mresp[1], mresptag[0], mresptag[1],
                 bus_reqcyc, bus_req, bus_reqtag, bus_respack};
  typedef struct packed {
    logic own;
    logic rd;
    logic [DW-1:0] addr;
    logic [TW-1:0] tag;
    logic [NB-1:0][DW-1:0] d;
  } xfer_t;
  xfer_t exp_q[$];
  logic model_last;
  bit [1:0] active, rd, ph;
  int cnt [2];
  logic [DW-1:0] addr [2];
  logic [TW-1:0] tag [2];
  logic [NB-1:0][DW-1:0] wd [2];
  int s_ph, s_cnt;
  logic [DW-1:0] s_addr;
  logic [TW-1:0] s_tag;
  function automatic logic [DW-1:0] rdata(logic [DW-1:0] a, int k);
    return a ^ (64'hA0 + 64'(k));
  endfunction
  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic chk_zero(string name);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s: outputs %h expected all zero at %0t", name, outs, $time);
    end
  endtask
  task automatic new_xfer(int i, bit force_rd);
    rd[i] = force_rd ? 1'b1 : 1'($urandom % 2);
    addr[i] = {32'h0, $urandom};
    tag[i] = {rd[i], 12'($urandom)};
    for (int k = 0; k < NB; k++) wd[i][k] = {$urandom, $urandom};
    active[i] = 1'b1;
    ph[i] = 1'b0;
    cnt[i] = 0;
  endtask
  function automatic xfer_t rec(int i);
    xfer_t r;
    r.own = 1'(i);
    r.rd = rd[i];
    r.addr = addr[i];
    r.tag = tag[i];
    for (int k = 0; k < NB; k++) r.d[k] = rd[i] ? rdata(addr[i], k) : wd[i][k];
    return r;
  endfunction
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      mreqcyc[i] = active[i] && (!ph[i] || (!rd[i] && ($urandom % 4 != 0)));
      mreq[i] = (active[i] && ph[i]) ? wd[i][cnt[i]] : addr[i];
      mreqtag[i] = tag[i];
      mrespack[i] = ($urandom % 4) != 0;
    end
    bus_reqack = ($urandom % 3) != 0;
    if (s_ph == 2) begin
      bus_respcyc = ($urandom % 4) != 0;
      bus_resp = rdata(s_addr, s_cnt);
      bus_resptag = s_tag;
    end else begin
      bus_respcyc = ($urandom % 6) == 0;
      bus_resp = {$urandom, $urandom};
      bus_resptag = 13'($urandom);
    end
  endtask
  task automatic sample();
    for (int i = 0; i < 2; i++) begin
      if (active[i]) begin
        if (!ph[i]) begin
          if (mreqcyc[i] && mreqack[i]) begin
            ph[i] = 1'b1;
            cnt[i] = 0;
          end
        end else if (!rd[i]) begin
          if (mreqcyc[i] && mreqack[i]) cnt[i]++;
        end else if (mrespcyc[i] && mrespack[i]) cnt[i]++;
        if (cnt[i] == NB) begin
          active[i] = 1'b0;
          ph[i] = 1'b0;
          cnt[i] = 0;
        end
      end
    end
    case (s_ph)
      0: if (bus_reqcyc && bus_reqack) begin
        s_addr = bus_req;
        s_tag = bus_reqtag;
        s_ph = bus_reqtag[12] ? 2 : 1;
        s_cnt = 0;
      end
      1: if (bus_reqcyc && bus_reqack) begin
        s_cnt++;
        if (s_cnt == NB) s_ph = 0;
      end
      default: if (bus_respcyc && bus_respack) begin
        s_cnt++;
        if (s_cnt == NB) s_ph = 0;
      end
    endcase
  endtask
  task automatic clear_drv();
    active = '0;
    ph = '0;
    cnt[0] = 0;
    cnt[1] = 0;
    s_ph = 0;
    s_cnt = 0;
  endtask
  // abort: m0 issues a forced read and the round stops after 4 response beats
  task automatic run_round(bit r0, bit r1, bit abort);
    int first;
    if (r0) new_xfer(0, abort);
    if (r1) new_xfer(1, 1'b0);
    if (r0 && r1) begin
      first = model_last ? 0 : 1;
      exp_q.push_back(rec(first));
      exp_q.push_back(rec(1 - first));
      model_last = 1'(1 - first);
    end else if (r0 || r1) begin
      exp_q.push_back(rec(r1 ? 1 : 0));
      model_last = r1;
    end
    for (int cyc = 0; cyc < 500 && (active != 0 || s_ph != 0); cyc++) begin
      @(negedge clk);
      drive();
      #4;
      if (cyc == 0) chk("idle_before_grant", 64'(bus_reqcyc), 64'(0));
      if (cyc == 1) chk("grant_latency", 64'(bus_reqcyc), 64'(1));
      sample();
      if (abort && ph[0] && cnt[0] == 4) return;
    end
    if (active != 0 || s_ph != 0) begin
      checks++;
      errors++;
      $display("FAIL round_timeout: active %b slave phase %0d still pending", active, s_ph);
      clear_drv();
    end
  endtask
  initial begin : monitor
    int mph, pm, mcnt;
    bit gap;
    xfer_t cur;
    mph = 0;
    mcnt = 0;
    gap = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        mph = 0;
        gap = 0;
      end else begin
        pm = mph;
        if (gap) begin
          chk("turnaround_idle", 64'(bus_reqcyc), 64'(0));
          gap = 0;
        end
        if (pm == 0) begin
          if (bus_reqcyc && bus_reqack) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_grant: address %h with nothing expected", bus_req);
            end else begin
              cur = exp_q.pop_front();
              chk("grant_owner", 64'(mreqack), cur.own ? 64'd2 : 64'd1);
              chk("addr_beat", bus_req, cur.addr);
              chk("addr_tag", 64'(bus_reqtag), 64'(cur.tag));
              mph = cur.rd ? 2 : 1;
              mcnt = 0;
            end
          end
        end else if (pm == 1) begin
          chk("wr_stall_mirror", 64'(bus_reqcyc), 64'(mreqcyc[cur.own]));
          if (bus_reqcyc && bus_reqack) begin
            chk("wdata_beat", bus_req, cur.d[mcnt]);
            chk("wack_route", 64'(mreqack), cur.own ? 64'd2 : 64'd1);
            mcnt++;
            if (mcnt == NB) begin
              mph = 0;
              gap = 1;
            end
          end
        end else begin
          chk("rd_reqcyc_low", 64'(bus_reqcyc), 64'(0));
          chk("respack_mirror", 64'(bus_respack), 64'(mrespack[cur.own]));
          chk("respcyc_route", 64'(mrespcyc), bus_respcyc ? (cur.own ? 64'd2 : 64'd1) : 64'd0);
          chk("nonowner_resp_zero", mresp[!cur.own], 64'(0));
          if (bus_respcyc && bus_respack) begin
            chk("rdata_beat", mresp[cur.own], cur.d[mcnt]);
            chk("resp_tag", 64'(mresptag[cur.own]), 64'(cur.tag));
            mcnt++;
            if (mcnt == NB) begin
              mph = 0;
              gap = 1;
            end
          end
        end
        if (pm != 2 && bus_respcyc) begin
          chk("stray_respack", 64'(bus_respack), 64'(0));
          chk("stray_respcyc", 64'(mrespcyc), 64'(0));
        end
      end
    end
  end
  initial begin
    logic [1:0] pat;
    mreqcyc = '0;
    mrespack = '0;
    for (int i = 0; i < 2; i++) begin
      mreq[i] = '0;
      mreqtag[i] = '0;
      addr[i] = '0;
      tag[i] = '0;
      wd[i] = '0;
    end
    bus_reqack = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp = '0;
    bus_resptag = '0;
    s_addr = '0;
    s_tag = '0;
    model_last = 1'b1;
    clear_drv();
    repeat (3) begin
      @(negedge clk);
      mreqcyc = 2'b11;
      mrespack = 2'b11;
      bus_reqack = 1'b1;
      bus_respcyc = 1'b1;
      bus_resp = {$urandom, $urandom};
      #1 chk_zero("in_reset_outputs");
    end
    @(negedge clk);
    mreqcyc = '0;
    bus_reqack = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus_respcyc = 1'b1;
      bus_resp = {$urandom, $urandom};
      bus_resptag = 13'($urandom);
      #4 chk_zero("spurious_idle");
    end
    bus_respcyc = 1'b0;
    run_round(1'b1, 1'b1, 1'b0);
    run_round(1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 40; r++) begin
      pat = 2'($urandom % 4);
      run_round(pat[0], pat[1], 1'b0);
      repeat ($urandom % 3) begin
        @(negedge clk);
        drive();
        #4 sample();
      end
    end
    run_round(1'b1, 1'b0, 1'b1);
    #2;
    bus_respcyc = 1'b1;
    mrespack = 2'b11;
    reset = 1'b0;
    #1 chk_zero("async_reset_mid_read");
    clear_drv();
    exp_q.delete();
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      mreqcyc = '0;
      bus_respcyc = 1'b1;
      mrespack = 2'b11;
      bus_resp = {$urandom, $urandom};
      #4 chk_zero("post_reset_stray");
    end
    run_round(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    mreqcyc = '0;
    bus_respcyc = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
